spi_host_rx_byte_packer: RTL and testbench

Packs the byte stream leaving the SPI host shift register's receive buffer into 32-bit words for the RX FIFO. It sits directly downstream of the shift register's rx_data/rx_valid/rx_ready/rx_last port and upstream of the RX FIFO write port. It closes a word after four bytes or on the byte flagged last, padding any unfilled lanes. Single-entry output register with full-throughput handshake, plus a synchronous software reset.

---
 rtl/spi_host_cmd_pkg.sv | 16 +
 rtl/spi_host_rx_byte_packer.sv | 115 +++++++++++
 tb/tb_spi_host_rx_byte_packer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_host_cmd_pkg.sv
// Shared SPI host command-path types and constants, including the RX byte packer's
// lane-order enum, state enum, word size and pad byte.
package spi_host_cmd_pkg;

  typedef enum logic {LittleEndian, BigEndian} byte_order_e;

  typedef enum logic {RxPackFill, RxPackHold} rx_pack_state_e;

  localparam int unsigned RxWordBytes = 4;
  localparam logic [7:0]  PadByte     = 8'h00;

  function automatic logic [31:0] pad_word();
    return {RxWordBytes{PadByte}};
  endfunction

endpackage

// File: rtl/spi_host_rx_byte_packer.sv
// Packs received SPI bytes into 32-bit RX FIFO words; early close on rx_last_i pads
// the unfilled lanes. Optional macro SPI_HOST_RX_BYTE_ORDER_EN adds byte_order_i.
module spi_host_rx_byte_packer
  import spi_host_cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        rx_last_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        word_last_o,
`ifdef SPI_HOST_RX_BYTE_ORDER_EN
  input  logic        byte_order_i,
`endif
  input  logic        sw_rst_i
);

  rx_pack_state_e state_q, state_d;
  logic [31:0]    acc_q, acc_d;
  logic [1:0]     idx_q, idx_d;
  logic           last_q, last_d;
  logic           drain_s;
  logic           accept_s;
  byte_order_e    order_s;

  // Lane k sits at bits [8k+7:8k] little-endian, mirrored for big-endian.
  function automatic logic [31:0] lane_write(input logic [31:0] acc, input logic [1:0] idx,
                                             input logic [7:0] data, input byte_order_e ord);
    logic [31:0] res;
    logic [1:0]  lane;
    res = acc;
    if (ord == BigEndian) begin
      lane = 2'd3 - idx;
    end else begin
      lane = idx;
    end
    case (lane)
      2'd0:    res[7:0]   = data;
      2'd1:    res[15:8]  = data;
      2'd2:    res[23:16] = data;
      2'd3:    res[31:24] = data;
      default: res        = acc;
    endcase
    return res;
  endfunction

`ifdef SPI_HOST_RX_BYTE_ORDER_EN
  assign order_s = byte_order_e'(byte_order_i);
`else
  assign order_s = LittleEndian;
`endif

  assign drain_s    = (state_q == RxPackHold) & word_ready_i;
  assign rx_ready_o = (state_q == RxPackFill) | drain_s;
  assign accept_s   = rx_valid_i & rx_ready_o;

  assign word_o       = acc_q;
  assign word_valid_o = (state_q == RxPackHold);
  assign word_last_o  = last_q;

  // Next-state: drain clears the word first so a same-cycle byte lands in lane 0.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (sw_rst_i) begin
      state_d = RxPackFill;
      acc_d   = pad_word();
      idx_d   = 2'd0;
      last_d  = 1'b0;
    end else begin
      if (drain_s) begin
        state_d = RxPackFill;
        acc_d   = pad_word();
        idx_d   = 2'd0;
        last_d  = 1'b0;
      end else begin
        state_d = state_q;
      end
      if (accept_s) begin
        acc_d = lane_write(acc_d, idx_d, rx_data_i, order_s);
        if ((idx_d == 2'(RxWordBytes - 1)) || rx_last_i) begin
          state_d = RxPackHold;
          last_d  = rx_last_i;
          idx_d   = 2'd0;
        end else begin
          idx_d   = idx_d + 2'd1;
        end
      end else begin
        acc_d = acc_d;
      end
    end
  end

  // State and word registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RxPackFill;
      acc_q   <= pad_word();
      idx_q   <= 2'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_spi_host_rx_byte_packer.sv
// Directed scoreboard bench for spi_host_rx_byte_packer; big-endian steps run only
// when SPI_HOST_RX_BYTE_ORDER_EN is defined.
module tb_spi_host_rx_byte_packer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic        rx_last_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        word_last_o;
  logic        sw_rst_i;
`ifdef SPI_HOST_RX_BYTE_ORDER_EN
  logic        byte_order_i;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        acc_seen;
  logic [32:0] exp_q[$];
  int          drain_q[$];

  spi_host_rx_byte_packer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_ready_o   (rx_ready_o),
    .rx_last_i    (rx_last_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_last_o  (word_last_o),
`ifdef SPI_HOST_RX_BYTE_ORDER_EN
    .byte_order_i (byte_order_i),
`endif
    .sw_rst_i     (sw_rst_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic l);
    exp_q.push_back({l, w});
  endtask

  // One clock: sample at negedge (scoreboard pop on drain), return at posedge+1.
  task automatic cycle();
    logic [32:0] e;
    @(negedge clk);
    acc_seen = rx_valid_i & rx_ready_o;
    if (word_valid_o && word_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", word_o, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        chk("word", word_o, e[31:0]);
        chk("word_last", {31'd0, word_last_o}, {31'd0, e[32]});
      end
      drain_q.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
    rx_valid_i = 1'b1;
    rx_data_i  = d;
    rx_last_i  = l;
    waited     = 0;
    do begin
      cycle();
      waited++;
    end while (!acc_seen && waited < 20);
    if (!acc_seen) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
  endtask

  initial begin
    int w;
    rst_ni       = 1'b0;
    rx_data_i    = 8'h00;
    rx_valid_i   = 1'b0;
    rx_last_i    = 1'b0;
    word_ready_i = 1'b1;
    sw_rst_i     = 1'b0;
`ifdef SPI_HOST_RX_BYTE_ORDER_EN
    byte_order_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    chk("rst_word_valid", {31'd0, word_valid_o}, 32'd0);
    chk("rst_word", word_o, 32'h0000_0000);
    chk("rst_word_last", {31'd0, word_last_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Full little-endian word, valid the cycle after the 4th byte
    push_exp(32'h4433_2211, 1'b0);
    send_byte(8'h11, 1'b0, w);
    send_byte(8'h22, 1'b0, w);
    send_byte(8'h33, 1'b0, w);
    chk("lat_before", {31'd0, word_valid_o}, 32'd0);
    send_byte(8'h44, 1'b0, w);
    chk("lat_valid", {31'd0, word_valid_o}, 32'd1);
    idle();
    cycle();
    cycle();

`ifdef SPI_HOST_RX_BYTE_ORDER_EN
    byte_order_i = 1'b1;
    push_exp(32'h1122_3344, 1'b0);
    send_byte(8'h11, 1'b0, w);
    send_byte(8'h22, 1'b0, w);
    send_byte(8'h33, 1'b0, w);
    send_byte(8'h44, 1'b0, w);
    idle();
    cycle();
    cycle();
    byte_order_i = 1'b0;
`endif

    // Early close with padding, then a 1-byte word accepted during drain
    push_exp(32'h0000_BBAA, 1'b1);
    send_byte(8'hAA, 1'b0, w);
    send_byte(8'hBB, 1'b1, w);
    push_exp(32'h0000_00CC, 1'b1);
    send_byte(8'hCC, 1'b1, w);
    chk("drain_accept_wait", w, 32'd1);
    idle();
    cycle();
    cycle();

    // Backpressure: 5 stalled cycles with byte 55 offered
    word_ready_i = 1'b0;
    push_exp(32'h4433_2211, 1'b0);
    push_exp(32'h8877_6655, 1'b0);
    send_byte(8'h11, 1'b0, w);
    send_byte(8'h22, 1'b0, w);
    send_byte(8'h33, 1'b0, w);
    send_byte(8'h44, 1'b0, w);
    rx_data_i = 8'h55;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rx_ready", {31'd0, rx_ready_o}, 32'd0);
      chk("stall_word", word_o, 32'h4433_2211);
      chk("stall_valid", {31'd0, word_valid_o}, 32'd1);
      cycle();
    end
    word_ready_i = 1'b1;
    send_byte(8'h55, 1'b0, w);
    send_byte(8'h66, 1'b0, w);
    send_byte(8'h77, 1'b0, w);
    send_byte(8'h88, 1'b0, w);
    idle();
    cycle();
    cycle();

    // Continuous 16-byte stream, no bubbles
    drain_q.delete();
    push_exp(32'h1312_1110, 1'b0);
    push_exp(32'h1716_1514, 1'b0);
    push_exp(32'h1B1A_1918, 1'b0);
    push_exp(32'h1F1E_1D1C, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i), 1'b0, w);
      chk("stream_no_bubble", w, 32'd1);
    end
    idle();
    cycle();
    cycle();
    chk("stream_words", drain_q.size(), 32'd4);
    if (drain_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("stream_spacing", drain_q[i] - drain_q[i-1], 32'd4);
    end

    // Soft reset discards a partial word
    send_byte(8'hA1, 1'b0, w);
    send_byte(8'hA2, 1'b0, w);
    idle();
    sw_rst_i = 1'b1;
    cycle();
    sw_rst_i = 1'b0;
    chk("srst_valid", {31'd0, word_valid_o}, 32'd0);
    chk("srst_word", word_o, 32'h0000_0000);
    cycle();
    cycle();
    push_exp(32'h0403_0201, 1'b0);
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h02, 1'b0, w);
    send_byte(8'h03, 1'b0, w);
    send_byte(8'h04, 1'b0, w);
    idle();
    cycle();
    cycle();

    // Asynchronous reset mid-word
    send_byte(8'hB1, 1'b0, w);
    send_byte(8'hB2, 1'b0, w);
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_word", word_o, 32'h0000_0000);
    chk("arst_valid", {31'd0, word_valid_o}, 32'd0);
    chk("arst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    push_exp(32'h0403_0201, 1'b0);
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h02, 1'b0, w);
    send_byte(8'h03, 1'b0, w);
    send_byte(8'h04, 1'b0, w);
    idle();
    cycle();
    cycle();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
